// File: rtl/emaxi_rd_engine.sv
// AXI4 read master: issues requests on AR with per-slot ARIDs and tracks up to MAX_OUT bursts.
// R beats pass combinationally to the response port, tagged with slot, last and error flags.
module emaxi_rd_engine #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 12,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ID_BASE = 0,
  localparam int unsigned SLOT_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1
) (
  input  logic                clk,
  input  logic                m_axi_aresetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [7:0]          req_len,
  input  logic [2:0]          req_size,
  input  logic [1:0]          req_burst,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [SLOT_W-1:0]   rsp_slot,
  output logic [1:0]          rsp_resp,
  output logic                rsp_last,
  output logic                rsp_err,
  input  logic                err_clr,
  output logic                err_unexp_id,
  output logic                err_last,
  output logic [MAX_OUT-1:0]  busy,
  output logic                rd_active
);

  logic                r_arvalid;
  logic [ID_W-1:0]     r_arid;
  logic [ADDR_W-1:0]   r_araddr;
  logic [7:0]          r_arlen;
  logic [2:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [MAX_OUT-1:0]  r_busy;
  logic [8:0]          r_cnt [MAX_OUT];
  logic                r_err_unexp;
  logic                r_err_last;

  logic                w_accept;
  logic [SLOT_W-1:0]   w_alloc_slot;
  logic [31:0]         w_rid_off;
  logic                w_rid_in_rng;
  logic [SLOT_W-1:0]   w_slot;
  logic                w_hit;
  logic [8:0]          w_cnt_cur;
  logic                w_cnt_one;
  logic                w_beat;
  logic                w_free;
  logic                w_last_bad;

  assign req_ready = (~r_arvalid | m_axi_arready) & ~(&r_busy);
  assign w_accept  = req_valid & req_ready;

  // Lowest free slot; scanning downward lets the lowest index overwrite higher ones.
  always_comb begin
    w_alloc_slot = '0;
    for (int k = int'(MAX_OUT) - 1; k >= 0; k--) begin
      if (!r_busy[k]) w_alloc_slot = SLOT_W'(k);
    end
  end

  assign w_rid_off    = 32'(m_axi_rid) - ID_BASE;
  assign w_rid_in_rng = (32'(m_axi_rid) >= ID_BASE) && (w_rid_off < MAX_OUT);
  assign w_slot       = w_rid_off[SLOT_W-1:0];
  assign w_hit        = w_rid_in_rng & r_busy[w_slot];
  assign w_cnt_cur    = r_cnt[w_slot];
  assign w_cnt_one    = (w_cnt_cur == 9'd1);
  assign w_last_bad   = m_axi_rlast ^ w_cnt_one;

  assign m_axi_rready = rsp_ready & m_axi_aresetn;
  assign w_beat       = m_axi_rvalid & m_axi_rready;
  // A slot closes on the counted last beat or on an early rlast, whichever comes first.
  assign w_free       = w_beat & w_hit & (w_cnt_one | m_axi_rlast);

  assign rsp_valid = m_axi_rvalid;
  assign rsp_data  = m_axi_rdata;
  assign rsp_resp  = m_axi_rresp;
  assign rsp_slot  = w_slot;
  assign rsp_last  = w_hit & w_cnt_one;
  assign rsp_err   = m_axi_rvalid & (~w_hit | w_last_bad);

  always_ff @(posedge clk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_arvalid   <= 1'b0;
      r_arid      <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arsize    <= '0;
      r_arburst   <= '0;
      r_busy      <= '0;
      r_err_unexp <= 1'b0;
      r_err_last  <= 1'b0;
      for (int k = 0; k < int'(MAX_OUT); k++) r_cnt[k] <= '0;
    end else begin
      if (w_accept) begin
        r_arvalid <= 1'b1;
        r_arid    <= ID_W'(ID_BASE) + ID_W'(w_alloc_slot);
        r_araddr  <= req_addr;
        r_arlen   <= req_len;
        r_arsize  <= req_size;
        r_arburst <= req_burst;
      end else if (m_axi_arready) begin
        r_arvalid <= 1'b0;
      end
      // Allocation only targets idle slots, so it never collides with a free.
      for (int k = 0; k < int'(MAX_OUT); k++) begin
        if (w_accept && (w_alloc_slot == SLOT_W'(k))) begin
          r_busy[k] <= 1'b1;
          r_cnt[k]  <= {1'b0, req_len} + 9'd1;
        end else if (w_beat && w_hit && (w_slot == SLOT_W'(k))) begin
          if (w_free) begin
            r_busy[k] <= 1'b0;
            r_cnt[k]  <= '0;
          end else begin
            r_cnt[k]  <= w_cnt_cur - 9'd1;
          end
        end
      end
      r_err_unexp <= (r_err_unexp & ~err_clr) | (w_beat & ~w_hit);
      r_err_last  <= (r_err_last & ~err_clr) | (w_beat & w_hit & w_last_bad);
    end
  end

  assign m_axi_arvalid = r_arvalid;
  assign m_axi_arid    = r_arid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = r_arlen;
  assign m_axi_arsize  = r_arsize;
  assign m_axi_arburst = r_arburst;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign busy          = r_busy;
  assign rd_active     = |r_busy;
  assign err_unexp_id  = r_err_unexp;
  assign err_last      = r_err_last;

endmodule
